// File: rtl/eth_pkt_pkg.sv
// Shared types for the eth_pkt store-and-forward transmitter.
// Word width, RAM entry layout and write-side FSM states.
package eth_pkt_pkg;

  localparam int WORD_W = 64;

  typedef logic [WORD_W-1:0] eth_word_t;

  typedef struct packed {
    logic      eop;
    eth_word_t data;
  } pkt_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    BODY,
    DROP
  } wr_state_t;

endpackage

// File: rtl/eth_pkt_ram.sv
// Simple dual-port DEPTH x pkt_entry_t RAM, synchronous read.
// Ports: clk; i_we/i_waddr/i_wdata write; i_re/i_raddr -> o_rdata.
module eth_pkt_ram
  import eth_pkt_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  pkt_entry_t    i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output pkt_entry_t    o_rdata
);

  pkt_entry_t r_mem [DEPTH];
  pkt_entry_t r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read data holds its value when i_re is low.
  always_ff @(posedge clk) begin
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/eth_pkt_tx.sv
// Store-and-forward packet transmitter feeding the eth_sw ingress.
// Ports: wr* host word stream in, tx* framed stream out, pktCnt/dropCnt.
module eth_pkt_tx
  import eth_pkt_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic [WORD_W-1:0] wrData,
  input  logic              wrSop,
  input  logic              wrEop,
  input  logic              wrVld,
  output logic              wrRdy,
  output logic [WORD_W-1:0] txData,
  output logic              txSop,
  output logic              txEop,
  output logic              txVld,
  input  logic              txRdy,
  output logic [CNT_W-1:0]  pktCnt,
  output logic [CNT_W-1:0]  dropCnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  wr_state_t         r_state, w_state_nxt;
  logic [AW:0]       r_wptr, r_cptr, r_rptr;
  logic [AW:0]       w_wptr_nxt, w_cptr_nxt, w_base;
  logic [AW:0]       r_pend;
  logic              r_live;
  logic              w_full, w_nofit, w_acc;
  logic              w_we, w_commit, w_drop;
  logic              r_s1, r_first;
  logic              r_tx_vld, r_tx_sop, r_tx_eop;
  logic [WORD_W-1:0] r_tx_data;
  logic [CNT_W-1:0]  r_pkt_cnt, r_drop_cnt;
  logic              w_adv, w_avail, w_re, w_done;
  pkt_entry_t        w_wentry, w_rentry;

  assign w_full = (r_wptr[AW] != r_rptr[AW]) &&
                  (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

  // Buffer holds nothing but the open packet: it can never fit.
  assign w_nofit = (r_state == BODY) && w_full &&
                   (r_cptr == r_rptr);

  assign wrRdy = r_live && ((r_state == DROP) || !w_full);
  assign w_acc = wrVld && wrRdy;

  assign w_wentry = '{eop: wrEop, data: wrData};

  always_comb begin
    w_state_nxt = r_state;
    w_wptr_nxt  = r_wptr;
    w_cptr_nxt  = r_cptr;
    w_base      = r_wptr;
    w_we        = 1'b0;
    w_commit    = 1'b0;
    w_drop      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_acc && wrSop) begin
          w_we       = 1'b1;
          w_wptr_nxt = r_wptr + PW'(1);
          if (wrEop) begin
            w_cptr_nxt = r_wptr + PW'(1);
            w_commit   = 1'b1;
          end else begin
            w_state_nxt = BODY;
          end
        end
      end
      BODY: begin
        if (w_nofit) begin
          w_wptr_nxt  = r_cptr;
          w_drop      = 1'b1;
          w_state_nxt = DROP;
        end else if (w_acc) begin
          // A fresh SOP restarts the packet at the commit point.
          w_base     = wrSop ? r_cptr : r_wptr;
          w_drop     = wrSop;
          w_we       = 1'b1;
          w_wptr_nxt = w_base + PW'(1);
          if (wrEop) begin
            w_cptr_nxt  = w_base + PW'(1);
            w_commit    = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      DROP: begin
        if (w_acc && wrEop) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Read side: s1 is the RAM read register, tx is the output stage.
  assign w_adv   = !r_tx_vld || txRdy;
  assign w_avail = (r_pend != '0) && (r_rptr != r_cptr);
  assign w_re    = w_avail && (!r_s1 || w_adv);
  assign w_done  = r_tx_vld && txRdy && r_tx_eop;

  eth_pkt_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_base[AW-1:0]),
    .i_wdata (w_wentry),
    .i_re    (w_re),
    .i_raddr (r_rptr[AW-1:0]),
    .o_rdata (w_rentry)
  );

  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_state    <= IDLE;
      r_wptr     <= '0;
      r_cptr     <= '0;
      r_rptr     <= '0;
      r_pend     <= '0;
      r_live     <= 1'b0;
      r_s1       <= 1'b0;
      r_first    <= 1'b1;
      r_tx_vld   <= 1'b0;
      r_tx_sop   <= 1'b0;
      r_tx_eop   <= 1'b0;
      r_tx_data  <= '0;
      r_pkt_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_live  <= 1'b1;
      r_state <= w_state_nxt;
      r_wptr  <= w_wptr_nxt;
      r_cptr  <= w_cptr_nxt;
      if (w_commit && !w_done) r_pend <= r_pend + PW'(1);
      if (!w_commit && w_done) r_pend <= r_pend - PW'(1);
      if (w_re) r_rptr <= r_rptr + PW'(1);
      if (w_re) r_s1 <= 1'b1;
      else if (w_adv) r_s1 <= 1'b0;
      if (w_adv) begin
        r_tx_vld <= r_s1;
        if (r_s1) begin
          r_tx_data <= w_rentry.data;
          r_tx_eop  <= w_rentry.eop;
          r_tx_sop  <= r_first;
          r_first   <= w_rentry.eop;
        end
      end
      if (w_done && r_pkt_cnt != '1)
        r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
      if (w_drop && r_drop_cnt != '1)
        r_drop_cnt <= r_drop_cnt + CNT_W'(1);
    end
  end

  assign txVld   = r_tx_vld;
  assign txData  = r_tx_data;
  assign txSop   = r_tx_vld && r_tx_sop;
  assign txEop   = r_tx_vld && r_tx_eop;
  assign pktCnt  = r_pkt_cnt;
  assign dropCnt = r_drop_cnt;

endmodule

// File: tb/tb_eth_pkt_tx.sv
// Scoreboard bench for eth_pkt_tx.
// Expected words are queued as packets are driven, popped on tx accept.
module tb_eth_pkt_tx;

  localparam int DEPTH = 64;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             resetN;
  logic [63:0]      wrData;
  logic             wrSop, wrEop, wrVld, wrRdy;
  logic [63:0]      txData;
  logic             txSop, txEop, txVld, txRdy;
  logic [CNT_W-1:0] pktCnt, dropCnt;

  int          n_chk = 0;
  int          n_err = 0;
  int          e_pkt = 0;
  int          e_drop = 0;
  logic [65:0] q[$];
  logic        hold = 1'b0;
  logic [66:0] held;
  logic        tog = 1'b0;

  eth_pkt_tx #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk     (clk),
    .resetN  (resetN),
    .wrData  (wrData),
    .wrSop   (wrSop),
    .wrEop   (wrEop),
    .wrVld   (wrVld),
    .wrRdy   (wrRdy),
    .txData  (txData),
    .txSop   (txSop),
    .txEop   (txEop),
    .txVld   (txVld),
    .txRdy   (txRdy),
    .pktCnt  (pktCnt),
    .dropCnt (dropCnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [67:0] obs,
                     input logic [67:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!resetN) begin
      hold = 1'b0;
    end else begin
      if (hold)
        chk("tx_stable", {txVld, txSop, txEop, txData}, held);
      if (txVld && txRdy) begin
        if (q.size() == 0) chk("tx_unexpected", txVld, 0);
        else chk("tx_word", {txSop, txEop, txData}, q.pop_front());
      end
      hold = txVld && !txRdy;
      held = {txVld, txSop, txEop, txData};
    end
  end

  task automatic wr(input logic [63:0] d,
                    input logic s, input logic e);
    int t = 0;
    @(negedge clk);
    wrData = d; wrSop = s; wrEop = e; wrVld = 1'b1;
    while (!wrRdy && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!wrRdy) chk("wr_timeout", wrRdy, 1);
    @(posedge clk);
    #1;
    wrVld = 1'b0; wrSop = 1'b0; wrEop = 1'b0;
  endtask

  task automatic send(input int n, input logic [63:0] base,
                      input bit push, input bit eop);
    logic [63:0] d;
    for (int i = 0; i < n; i++) begin
      d = base * 64'(i + 1);
      if (push)
        q.push_back({i == 0, eop && (i == n - 1), d});
      wr(d, i == 0, eop && (i == n - 1));
    end
    if (push && eop) e_pkt++;
  endtask

  task automatic drain();
    int t = 0;
    while ((q.size() != 0 || txVld) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_q", q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int gap;
    resetN = 1'b0; txRdy = 1'b1;
    wrData = '0; wrSop = 1'b0; wrEop = 1'b0; wrVld = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wrRdy", wrRdy, 0);
    chk("rst_txVld", txVld, 0);
    chk("rst_txData", txData, 0);
    chk("rst_pktCnt", pktCnt, 0);
    chk("rst_dropCnt", dropCnt, 0);
    @(posedge clk); #1 resetN = 1'b1;
    @(negedge clk);
    chk("rel_wrRdy_lo", wrRdy, 0);
    @(negedge clk);
    chk("rel_wrRdy_hi", wrRdy, 1);

    // 4-word packet and first-word latency
    send(4, 64'h1111, 1, 1);
    @(negedge clk); chk("lat_c1", txVld, 0);
    @(negedge clk); chk("lat_c2", txVld, 0);
    @(negedge clk); chk("lat_c3", txVld, 1);
    drain();
    chk("t1_pktCnt", pktCnt, e_pkt);

    // single-word packet
    send(1, 64'hDEAD, 1, 1);
    drain();
    chk("t2_pktCnt", pktCnt, e_pkt);

    // SOP inside a body drops the partial packet
    send(3, 64'hA000_0001, 0, 0);
    send(3, 64'hB000_0001, 1, 1);
    e_drop++;
    drain();
    chk("t3_dropCnt", dropCnt, e_drop);
    chk("t3_pktCnt", pktCnt, e_pkt);

    // oversized packet can never fit
    txRdy = 1'b0;
    send(DEPTH + 2, 64'hC000_0001, 0, 1);
    e_drop++;
    repeat (3) @(negedge clk);
    chk("t4_dropCnt", dropCnt, e_drop);
    chk("t4_txVld", txVld, 0);
    send(2, 64'hD000_0001, 1, 1);
    #1 txRdy = 1'b1;
    drain();
    chk("t4_pktCnt", pktCnt, e_pkt);

    // two packets under toggling backpressure
    tog = 1'b1;
    fork
      begin
        while (tog) begin
          @(posedge clk);
          #1 txRdy = ~txRdy;
        end
      end
    join_none
    send(8, 64'hE000_0001, 1, 1);
    send(8, 64'hF000_0001, 1, 1);
    gap = 0; t = 0;
    while (pktCnt != CNT_W'(e_pkt) && t < 500) begin
      @(negedge clk);
      t++;
      if (pktCnt != CNT_W'(e_pkt) && !txVld) gap++;
    end
    chk("t5_gap", gap, 0);
    drain();
    tog = 1'b0;
    @(posedge clk); #2 txRdy = 1'b1;
    chk("t5_pktCnt", pktCnt, e_pkt);

    // reset in the middle of a transmit
    send(10, 64'h5000_0001, 1, 1);
    repeat (4) @(negedge clk);
    @(posedge clk); #1 resetN = 1'b0;
    q.delete();
    e_pkt = 0; e_drop = 0;
    @(posedge clk);
    @(negedge clk);
    chk("t6_txVld", txVld, 0);
    chk("t6_pktCnt", pktCnt, 0);
    chk("t6_dropCnt", dropCnt, 0);
    chk("t6_wrRdy", wrRdy, 0);
    @(posedge clk); #1 resetN = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_idle", txVld, 0);
    send(3, 64'h6000_0001, 1, 1);
    drain();
    chk("t6_pktCnt_post", pktCnt, e_pkt);
    chk("t6_dropCnt_post", dropCnt, e_drop);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/eth_pkt_tx.md
Name: eth_pkt_tx

Overview:
- Store-and-forward packet transmitter that drives the eth_sw ingress stream (inData/inSop/inEop/vld).
- A host side writes 64-bit packet words framed by SOP/EOP into an internal buffer.
- A packet becomes eligible for transmission only after its EOP word is accepted. It is then sent back-to-back with SOP/EOP framing, honouring downstream backpressure.
- Malformed packets are dropped in the buffer and never reach the switch.

Parameters:
- DEPTH, 64, buffer depth in 64-bit words; power of two, minimum 4.
- CNT_W, 16, width of the packet and drop statistics counters.

Ports:
- clk  input  1  system clock, rising edge.
- resetN  input  1  synchronous active-low reset.
- wrData  input  64  host packet word.
- wrSop  input  1  first word of packet.
- wrEop  input  1  last word of packet; SOP and EOP together means a 1-word packet.
- wrVld  input  1  host word valid.
- wrRdy  output  1  buffer can accept a word this cycle.
- txData  output  64  word to switch (connects to inData).
- txSop  output  1  start-of-packet pulse to switch.
- txEop  output  1  end-of-packet pulse to switch.
- txVld  output  1  txData/txSop/txEop valid.
- txRdy  input  1  downstream accepts the word when txVld and txRdy are both high.
- pktCnt  output  CNT_W  packets fully transmitted; saturating.
- dropCnt  output  CNT_W  packets dropped; saturating.

Behaviour:
- Reset: all pointers, counters and FSM states clear on a clk edge with resetN=0.
  - Outputs during and after reset: wrRdy=0, txVld=0, txSop=0, txEop=0, txData=0, pktCnt=0, dropCnt=0.
  - wrRdy rises the cycle after resetN=1.
  - Reset mid-packet discards all buffered data on both sides. There is no partial output.
- Write side: a word is accepted when wrVld and wrRdy are both high. Each entry stores {eop, data}.
  - wrRdy = not full (speculative write pointer vs read pointer).
- Write FSM states:
  - IDLE: the first accepted word must carry wrSop. A word without SOP is discarded and does not count as a drop.
  - IDLE -> BODY on SOP without EOP.
  - BODY -> IDLE on an EOP word. At that edge the committed pointer takes the speculative pointer and the packet count increments.
  - SOP while in BODY: the current partial packet is dropped (speculative pointer rewinds to committed pointer, dropCnt+1). The new SOP word is then written as the start of a new packet in the same cycle.
  - Buffer full while in BODY and the committed pointer equals the read pointer: the packet can never fit. Rewind, dropCnt+1, and return to a DROP state. DROP swallows words, with wrRdy=1, until EOP, then returns to IDLE.
- Read side: a packet is eligible when the committed packet count is greater than 0.
  - RAM read is synchronous. An output register stage holds the head word; txVld stays high until txRdy is seen.
  - txSop is asserted on the first word of each packet; txEop mirrors the stored eop bit.
  - Packets go back-to-back with no bubble when the next packet is already committed.
  - Packet count decrements and pktCnt increments when the EOP word is accepted by txRdy.
- Latency: EOP accepted at edge N gives txVld=1 with the first word at edge N+2, provided the buffer was empty and txRdy was high.
- Simultaneous commit and transmit completion in one cycle: the packet count is unchanged.
- Pointers are log2(DEPTH)+1 bits with a wrap bit. Full/empty are determined by MSB compare.
- Counters saturate at all-ones.

Decomposition:
- Package eth_pkt_pkg holds:
  - WORD_W=64.
  - typedef eth_word_t (logic [WORD_W-1:0]).
  - struct pkt_entry_t {eop, data}.
  - enum wr_state_t {IDLE, BODY, DROP}.
- One sub-module, eth_pkt_ram: simple dual-port DEPTH x pkt_entry_t RAM with one write port and a synchronous read port.

Test Plan:
- Single 4-word packet D0..D3 (0x1111..0x4444), txRdy=1 -> txVld high 2 cycles after EOP write. txSop only on 0x1111, txEop only on 0x4444. pktCnt=1.
- 1-word packet with wrSop=wrEop=1, data 0xDEAD -> one tx cycle with txSop=txEop=1 and data 0xDEAD.
- 3 words of a packet, then a new SOP before EOP -> first packet never appears on tx. dropCnt=1. The second packet transmits intact.
- Packet of DEPTH+2 words with txRdy low -> dropped (DROP state). dropCnt=1, no tx words. A following 2-word packet transmits normally.
- Two 8-word packets with txRdy toggling every cycle -> all 16 words in order, txVld/txData stable while txRdy=0, packets back-to-back. pktCnt=2.
- resetN pulled low mid-transmit of a 10-word packet -> txVld=0 the next cycle, counters=0. The post-reset packet transmits correctly.
